// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM states and header field positions.
package loader_pkg;

   typedef enum logic [2:0] {
      WAIT_HDR,
      LOAD,
      CHECK,
      RUN,
      FAULT
   } loader_state_t;

   // Header byte: [7:4] base address, [3:0] payload length minus one
   localparam int HDR_BASE_MSB = 7;
   localparam int HDR_BASE_LSB = 4;
   localparam int HDR_CNT_MSB  = 3;
   localparam int HDR_CNT_LSB  = 0;

endpackage

// File: rtl/program_loader.sv
// Framed byte-stream loader for the CPU program RAM: writes the payload,
// checks an XOR checksum and releases the CPU core only after a good frame.
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              load_req,
   output logic              input_mode,
   output logic [ADDR_W-1:0] input_address,
   output logic [DATA_W-1:0] input_program,
   output logic              cpu_reset,
   output logic              busy,
   output logic              error
);

   loader_state_t     state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] chk_q, chk_d;
   logic              in_ready_q, in_ready_d;
   logic              mode_q, mode_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] prog_q, prog_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              busy_q, busy_d;
   logic              error_q, error_d;
   logic              accept;

   assign accept = in_valid && in_ready_q;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      chk_d       = chk_q;
      mode_d      = mode_q;
      addr_d      = addr_q;
      prog_d      = prog_q;
      cpu_reset_d = cpu_reset_q;
      error_d     = error_q;

      case (state_q)
         WAIT_HDR, FAULT: begin
            if (accept) begin
               base_d  = in_data[HDR_BASE_MSB:HDR_BASE_LSB];
               cnt_d   = in_data[HDR_CNT_MSB:HDR_CNT_LSB];
               idx_d   = '0;
               chk_d   = in_data;
               error_d = 1'b0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (accept) begin
               // Address sum is ADDR_W bits wide, so it wraps past the top of RAM
               addr_d = base_q + idx_q;
               prog_d = in_data;
               mode_d = 1'b1;
               chk_d  = chk_q ^ in_data;
               idx_d  = idx_q + 1'b1;
               if (idx_q == cnt_q) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            if (accept) begin
               mode_d = 1'b0;
               if (in_data == chk_q) begin
                  cpu_reset_d = 1'b1;
                  state_d     = RUN;
               end else begin
                  error_d = 1'b1;
                  state_d = FAULT;
               end
            end
         end
         RUN: begin
            if (load_req) begin
               cpu_reset_d = 1'b0;
               state_d     = WAIT_HDR;
            end
         end
         default: state_d = WAIT_HDR;
      endcase

      // Status flags are registered copies of the next state
      in_ready_d = (state_d != RUN);
      busy_d     = (state_d == LOAD) || (state_d == CHECK);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= WAIT_HDR;
         base_q      <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         chk_q       <= '0;
         in_ready_q  <= 1'b0;
         mode_q      <= 1'b0;
         addr_q      <= '0;
         prog_q      <= '0;
         cpu_reset_q <= 1'b0;
         busy_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         chk_q       <= chk_d;
         in_ready_q  <= in_ready_d;
         mode_q      <= mode_d;
         addr_q      <= addr_d;
         prog_q      <= prog_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         error_q     <= error_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign input_mode    = mode_q;
   assign input_address = addr_q;
   assign input_program = prog_q;
   assign cpu_reset     = cpu_reset_q;
   assign busy          = busy_q;
   assign error         = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus random frames
// compared against a frame-level reference of RAM contents and release status.
module tb_program_loader;

   logic       clk;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       load_req;
   logic       input_mode;
   logic [3:0] input_address;
   logic [7:0] input_program;
   logic       cpu_reset;
   logic       busy;
   logic       error;

   program_loader #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .load_req      (load_req),
      .input_mode    (input_mode),
      .input_address (input_address),
      .input_program (input_program),
      .cpu_reset     (cpu_reset),
      .busy          (busy),
      .error         (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;
   logic overlap_seen = 1'b0;

   logic [7:0] ram [16];
   logic [7:0] exp_ram [16];
   logic [7:0] frame_q [$];

   // The program RAM as the CPU sees it
   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (input_mode) ram[input_address] <= input_program;
   end

   always @(negedge clk) begin
      if (cpu_reset && input_mode) overlap_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one byte after `gap` idle cycles; returns at the negedge after acceptance
   task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cycle);
      int w;
      bit done;
      w = 0;
      done = 0;
      acc_cycle = -1;
      repeat (gap) @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      while (!done && w < 50) begin
         if (in_ready) begin
            @(posedge clk);
            acc_cycle = cycle;
            done = 1;
         end
         @(negedge clk);
         w++;
      end
      in_valid = 1'b0;
      if (!done) check("accept_timeout", 32'd0, 32'd1);
   endtask

   // Sends header, frame_q payload and checksum, then checks outcome against the reference
   task automatic send_frame(input logic [7:0] hdr, input logic [7:0] csum, input int gap);
      int c0, c1, cx, n;
      logic [7:0] x;
      logic [3:0] a;
      bit good;
      n = frame_q.size();
      x = hdr;
      send_byte(hdr, 0, c0);
      check("hdr_err_clr", 32'(error), 32'd0);
      check("hdr_busy", 32'(busy), 32'd1);
      for (int i = 0; i < n; i++) begin
         send_byte(frame_q[i], gap, cx);
         x = x ^ frame_q[i];
         a = 4'((hdr >> 4) + i);
         exp_ram[a] = frame_q[i];
      end
      send_byte(csum, gap, c1);
      good = (csum == x);
      if (gap == 0) check("throughput", 32'(c1 - c0), 32'(n + 1));
      check("end_mode", 32'(input_mode), 32'd0);
      check("end_busy", 32'(busy), 32'd0);
      check("end_cpu_reset", 32'(cpu_reset), 32'(good));
      check("end_error", 32'(error), 32'(!good));
      check("end_ready", 32'(in_ready), 32'(!good));
      for (int i = 0; i < 16; i++) check($sformatf("ram[%0d]", i), 32'(ram[i]), 32'(exp_ram[i]));
      $display("frame hdr=%02h n=%0d csum=%02h gap=%0d good=%0d", hdr, n, csum, gap, good);
   endtask

   task automatic reload();
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      check("reload_cpu_reset", 32'(cpu_reset), 32'd0);
      check("reload_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] hdr, x;
      int n, gap, dummy;
      bit bad;
      for (int i = 0; i < 16; i++) begin
         ram[i] = 8'h00;
         exp_ram[i] = 8'h00;
      end
      reset = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      load_req = 1'b0;
      #1;
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_outs", {26'd0, input_mode, cpu_reset, busy, error, 2'd0}, 32'd0);
      check("rst_addr_prog", {20'd0, input_address, input_program}, 32'd0);
      repeat (3) @(negedge clk);
      check("rst_ready_held", 32'(in_ready), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(in_ready), 32'd1);

      // load_req outside RUN has no effect
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      check("ignored_req_ready", 32'(in_ready), 32'd1);
      check("ignored_req_busy", 32'(busy), 32'd0);

      frame_q = '{8'h79, 8'hA0, 8'h00};
      send_frame(8'h02, 8'hDB, 0);

      // Bytes offered in RUN must be refused
      in_data = 8'h55;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      check("run_ready", 32'(in_ready), 32'd0);
      check("run_cpu_reset", 32'(cpu_reset), 32'd1);
      check("run_busy", 32'(busy), 32'd0);
      reload();

      frame_q = '{8'h01, 8'h08};
      send_frame(8'h91, 8'h98, 0);
      check("mov_a_9", 32'(ram[9]), 32'h01);
      reload();

      frame_q = '{8'h11, 8'h22};
      send_frame(8'hF1, 8'hC2, 0);
      reload();

      frame_q = '{8'h79, 8'hA0, 8'h00};
      send_frame(8'h02, 8'hDA, 0);
      frame_q = '{8'h79, 8'hA0, 8'h00};
      send_frame(8'h02, 8'hDB, 3);
      reload();

      // Reset mid-frame, right after the second data byte is accepted
      send_byte(8'h02, 0, dummy);
      send_byte(8'h79, 0, dummy);
      send_byte(8'hA0, 0, dummy);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_outs", {26'd0, in_ready, input_mode, cpu_reset, busy, error, 1'b0}, 32'd0);
      check("mid_rst_addr_prog", {20'd0, input_address, input_program}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      exp_ram[0] = 8'h79;
      @(negedge clk);
      frame_q = '{8'h79, 8'hA0, 8'h00};
      send_frame(8'h02, 8'hDB, 0);
      reload();

      for (int f = 0; f < 25; f++) begin
         hdr = 8'($urandom_range(0, 255));
         n = int'(hdr[3:0]) + 1;
         frame_q = {};
         x = hdr;
         for (int i = 0; i < n; i++) begin
            frame_q.push_back(8'($urandom_range(0, 255)));
            x = x ^ frame_q[i];
         end
         bad = ($urandom_range(0, 3) == 0);
         if (bad) x = x ^ 8'($urandom_range(1, 255));
         gap = $urandom_range(0, 2);
         send_frame(hdr, x, gap);
         if (!bad) reload();
      end

      check("mode_with_cpu_run", 32'(overlap_seen), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
